// File: rtl/lsu_mem_ctrl.sv
// Load/store front-end to a 1-cycle byte-enabled SRAM; optional counters under LSU_PERF_CNT_EN.
// Accept-to-resp_valid: load 3, store 2, error 1 cycles; one request in flight, held in RESP until resp_ready.
module lsu_mem_ctrl #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic [31:0]      mem_address,
  output logic [WIDTH-1:0] mem_write_data,
  output logic [3:0]       mem_write_byte_enable,
  output logic             mem_write_enable,
  output logic             mem_read_enable,
  input  logic [WIDTH-1:0] mem_read_data
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0]      perf_loads,
  output logic [31:0]      perf_stores,
  output logic [31:0]      perf_errs
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              unsigned_q, unsigned_d;
  logic [31:0]       addr_q, addr_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [WIDTH-1:0]  ld_ext;
  logic              unused_addr;

  assign req_err = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  // Lane extraction runs off the registered address so it lines up with the SRAM read word.
  always_comb begin
    ld_byte = 8'h00;
    ld_half = addr_q[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    ld_ext  = mem_read_data;
    case (addr_q[1:0])
      2'd0:    ld_byte = mem_read_data[7:0];
      2'd1:    ld_byte = mem_read_data[15:8];
      2'd2:    ld_byte = mem_read_data[23:16];
      default: ld_byte = mem_read_data[31:24];
    endcase
    case (size_q)
      2'd0:    ld_ext = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{~unsigned_q & ld_half[15]}}, ld_half};
      default: ld_ext = mem_read_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = req_err;
          state_d    = req_err ? RESP : ACCESS;
        end
      end
      ACCESS:  state_d = write_q ? RESP : CAPTURE;
      CAPTURE: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;
  assign mem_address = {{(32-ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};
  assign unused_addr = ^{addr_q[31:ADDR_BITS+2], addr_q[1:0]};

  always_comb begin
    mem_write_enable      = (state_q == ACCESS) & write_q;
    mem_read_enable       = (state_q == ACCESS) & ~write_q;
    mem_write_byte_enable = 4'b0000;
    case (size_q)
      2'd0:    mem_write_data = {4{wdata_q[7:0]}};
      2'd1:    mem_write_data = {2{wdata_q[15:0]}};
      default: mem_write_data = wdata_q;
    endcase
    if (mem_write_enable) begin
      case (size_q)
        2'd0:    mem_write_byte_enable = 4'b0001 << addr_q[1:0];
        2'd1:    mem_write_byte_enable = addr_q[1] ? 4'b1100 : 4'b0011;
        default: mem_write_byte_enable = 4'b1111;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads_q, perf_loads_d;
  logic [31:0] perf_stores_q, perf_stores_d;
  logic [31:0] perf_errs_q, perf_errs_d;

  // Counters bump on the response handshake; errored requests land only in perf_errs.
  always_comb begin
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    perf_errs_d   = perf_errs_q;
    if ((state_q == RESP) && resp_ready) begin
      if (err_q)        perf_errs_d   = perf_errs_q + 32'd1;
      else if (write_q) perf_stores_d = perf_stores_q + 32'd1;
      else              perf_loads_d  = perf_loads_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads_q  <= '0;
      perf_stores_q <= '0;
      perf_errs_q   <= '0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
      perf_errs_q   <= perf_errs_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
  assign perf_errs   = perf_errs_q;
`endif

endmodule
